// File: rtl/button_event_ctrl.sv
// Multi-channel pushbutton controller: shared tick prescaler, per-channel
// synchronizer/debouncer/event FSM with a one-deep pending slot, and a
// round-robin arbiter feeding a single valid/ready event port.

module button_event_chan #(
   parameter int STABLE_TICKS = 4,
   parameter int LONG_TICKS   = 50,
   parameter int REPEAT_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_tick,
   input  logic       i_btn,
   input  logic       i_grant,
   output logic       o_level,
   output logic       o_full,
   output logic [1:0] o_type,
   output logic       o_drop
);
   localparam int SW = $clog2(STABLE_TICKS + 1);
   localparam int HW = $clog2(LONG_TICKS + 1);
   localparam int RW = $clog2(REPEAT_TICKS + 1);

   localparam logic [1:0] EV_PRESS   = 2'd0;
   localparam logic [1:0] EV_RELEASE = 2'd1;
   localparam logic [1:0] EV_LONG    = 2'd2;
   localparam logic [1:0] EV_REPEAT  = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_DOWN, ST_HELD} state_t;

   logic          r_sync1, r_sync2, r_level, r_level_d;
   logic [SW-1:0] r_stab;
   state_t        r_state;
   logic [HW-1:0] r_hold;
   logic [RW-1:0] r_rep;
   logic          r_full;
   logic [1:0]    r_type;

   logic          w_rise, w_fall, w_fire;
   logic [1:0]    w_ev;

   assign w_rise  = r_level & ~r_level_d;
   assign w_fall  = ~r_level & r_level_d;
   assign o_level = r_level;
   assign o_full  = r_full;
   assign o_type  = r_type;
   // A new event is lost only if the slot stays occupied this cycle.
   assign o_drop  = w_fire & r_full & ~i_grant;

   // Synchronize the raw input and debounce it on sample ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_stab    <= '0;
      end else begin
         r_sync1   <= i_btn;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         if (i_tick) begin
            if (r_sync2 != r_level) begin
               if (r_stab == SW'(STABLE_TICKS - 1)) begin
                  r_level <= r_sync2;
                  r_stab  <= '0;
               end else begin
                  r_stab <= r_stab + 1'b1;
               end
            end else begin
               r_stab <= '0;
            end
         end
      end
   end

   // Decode which event (if any) the FSM raises this cycle; a fall beats LONG/REPEAT.
   always_comb begin
      w_fire = 1'b0;
      w_ev   = EV_PRESS;
      case (r_state)
         ST_IDLE: if (w_rise) w_fire = 1'b1;
         ST_DOWN: begin
            if (w_fall) begin
               w_fire = 1'b1;
               w_ev   = EV_RELEASE;
            end else if (i_tick && r_hold == HW'(LONG_TICKS - 1)) begin
               w_fire = 1'b1;
               w_ev   = EV_LONG;
            end
         end
         ST_HELD: begin
            if (w_fall) begin
               w_fire = 1'b1;
               w_ev   = EV_RELEASE;
            end else if (i_tick && r_rep == RW'(REPEAT_TICKS - 1)) begin
               w_fire = 1'b1;
               w_ev   = EV_REPEAT;
            end
         end
         default: ;
      endcase
   end

   // Event FSM with hold/repeat counters and the registered pending slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_hold  <= '0;
         r_rep   <= '0;
         r_full  <= 1'b0;
         r_type  <= EV_PRESS;
      end else begin
         if (w_fire) begin
            unique case (w_ev)
               EV_PRESS:   begin r_state <= ST_DOWN; r_hold <= '0; end
               EV_RELEASE: r_state <= ST_IDLE;
               EV_LONG:    begin r_state <= ST_HELD; r_rep <= '0; end
               EV_REPEAT:  r_rep <= '0;
            endcase
         end else if (i_tick) begin
            if (r_state == ST_DOWN) r_hold <= r_hold + 1'b1;
            if (r_state == ST_HELD) r_rep  <= r_rep + 1'b1;
         end
         // A grant in the same cycle frees the slot for the incoming event.
         if (w_fire && (!r_full || i_grant)) begin
            r_full <= 1'b1;
            r_type <= w_ev;
         end else if (i_grant) begin
            r_full <= 1'b0;
         end
      end
   end
endmodule

module button_event_ctrl #(
   parameter int N            = 4,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 4,
   parameter int LONG_TICKS   = 50,
   parameter int REPEAT_TICKS = 10,
   localparam int CW          = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  btn_in,
   output logic [N-1:0]  level,
   output logic          ev_valid,
   input  logic          ev_ready,
   output logic [CW-1:0] ev_chan,
   output logic [1:0]    ev_type,
   output logic          ev_drop
);
   localparam int TW = $clog2(TICK_DIV);

   logic [TW-1:0]       r_tick_cnt;
   logic                w_tick;
   logic [N-1:0]        w_full, w_grant, w_drop;
   logic [N-1:0][1:0]   w_type;
   logic                w_load, w_found;
   logic [CW-1:0]       w_win;
   logic [CW-1:0]       r_ptr;
   logic                r_valid, r_drop;
   logic [CW-1:0]       r_chan;
   logic [1:0]          r_type;

   assign w_tick   = (r_tick_cnt == TW'(TICK_DIV - 1));
   assign w_load   = ~r_valid | ev_ready;
   assign ev_valid = r_valid;
   assign ev_chan  = r_chan;
   assign ev_type  = r_type;
   assign ev_drop  = r_drop;

   // Free-running sample-tick prescaler.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   for (genvar g = 0; g < N; g++) begin : g_chan
      button_event_chan #(
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_tick  (w_tick),
         .i_btn   (btn_in[g]),
         .i_grant (w_grant[g]),
         .o_level (level[g]),
         .o_full  (w_full[g]),
         .o_type  (w_type[g]),
         .o_drop  (w_drop[g])
      );
   end

   // Round-robin search for the first full slot at or above the pointer.
   always_comb begin
      int v_idx;
      v_idx   = 0;
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < N; i++) begin
         v_idx = int'(r_ptr) + i;
         if (v_idx >= N) v_idx = v_idx - N;
         if (!w_found && w_full[CW'(v_idx)]) begin
            w_found = 1'b1;
            w_win   = CW'(v_idx);
         end
      end
   end

   // One-hot grant, only when the output register is free to load.
   always_comb begin
      w_grant = '0;
      if (w_load && w_found) w_grant[w_win] = 1'b1;
   end

   // Output register, RR pointer and the registered drop pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_chan  <= '0;
         r_type  <= 2'd0;
         r_ptr   <= '0;
         r_drop  <= 1'b0;
      end else begin
         r_drop <= |w_drop;
         if (w_load) begin
            if (w_found) begin
               r_valid <= 1'b1;
               r_chan  <= w_win;
               r_type  <= w_type[w_win];
               r_ptr   <= (w_win == CW'(N - 1)) ? '0 : w_win + 1'b1;
            end else begin
               r_valid <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: expected events (channel, type,
// cycle of first visibility) are queued as stimulus is applied and matched
// against the accepted-event stream captured on the falling clock edge.

module tb_button_event_ctrl;
   localparam int N = 4, TICK_DIV = 4, STABLE = 3, LONGT = 8, REPT = 2;
   localparam int T_PRESS = 0, T_RELEASE = 1, T_LONG = 2, T_REPEAT = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] btn_in = '0;
   logic         ev_ready = 1'b0;
   logic [N-1:0] level;
   logic         ev_valid, ev_drop;
   logic [1:0]   ev_chan, ev_type;

   button_event_ctrl #(
      .N(N), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE),
      .LONG_TICKS(LONGT), .REPEAT_TICKS(REPT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .level(level),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_chan(ev_chan),
      .ev_type(ev_type), .ev_drop(ev_drop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int chan; int typ; int cyc; } ev_t;
   ev_t exp_q[$];
   ev_t got_q[$];
   ev_t mon_e;
   int  n_vec = 0, n_bad = 0;
   int  valid_cnt = 0, drop_cnt = 0, last_drop_cyc = -1;

   // Capture every accepted event and every drop pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ev_valid) valid_cnt++;
         if (ev_drop) begin drop_cnt++; last_drop_cyc = cyc; end
         if (ev_valid && ev_ready) begin
            mon_e.chan = int'(ev_chan);
            mon_e.typ  = int'(ev_type);
            mon_e.cyc  = cyc;
            got_q.push_back(mon_e);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_level(input int b, input logic v, input int budget, output int c);
      c = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (level[b] === v) begin c = cyc; break; end
      end
   endtask

   task automatic push_ev(input int ch, input int t, input int c);
      ev_t e;
      e.chan = ch; e.typ = t; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; btn_in = '0; ev_ready = 1'b0;
      step(3);
      n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
      n_vec++; if (ev_chan !== 2'd0) begin n_bad++; $display("FAIL reset_chan: got %0d want 0", ev_chan); end
      n_vec++; if (ev_type !== 2'd0) begin n_bad++; $display("FAIL reset_type: got %0d want 0", ev_type); end
      n_vec++; if (ev_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got %b want 0", ev_drop); end
      rst_n = 1'b1;
      step(200);
      n_vec++; if (level !== 4'b0000) begin n_bad++; $display("FAIL idle_level: got %b want 0000", level); end
      n_vec++; if (valid_cnt != 0) begin n_bad++; $display("FAIL idle_valid: got %0d valid cycles want 0", valid_cnt); end
      n_vec++; if (drop_cnt != 0) begin n_bad++; $display("FAIL idle_drop: got %0d drops want 0", drop_cnt); end
   endtask

   task automatic test_press_release();
      int k, L, F;
      ev_t e, g;
      ev_ready = 1'b1;
      k = cyc; btn_in[1] = 1'b1;
      wait_level(1, 1'b1, 40, L);
      n_vec++;
      if (L < 0) begin n_bad++; $display("FAIL pr_rise: level[1] never rose within 40 cycles"); end
      else if (L - k < 11 || L - k > 14) begin n_bad++; $display("FAIL pr_rise_delay: got %0d cycles want 11..14", L - k); end
      n_vec++; if (level !== 4'b0010) begin n_bad++; $display("FAIL pr_level: got %b want 0010", level); end
      push_ev(1, T_PRESS, L + 2);
      step(1);
      btn_in[1] = 1'b0;
      wait_level(1, 1'b0, 40, F);
      n_vec++; if (F < 0) begin n_bad++; $display("FAIL pr_fall: level[1] never fell within 40 cycles"); end
      push_ev(1, T_RELEASE, F + 2);
      step(8);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_vec++;
         if (got_q.size() == 0) begin n_bad++; $display("FAIL pr_event: missing, want chan %0d type %0d at cycle %0d", e.chan, e.typ, e.cyc); end
         else begin
            g = got_q.pop_front();
            if (g.chan !== e.chan || g.typ !== e.typ || g.cyc !== e.cyc) begin
               n_bad++; $display("FAIL pr_event: got chan %0d type %0d cyc %0d want chan %0d type %0d cyc %0d", g.chan, g.typ, g.cyc, e.chan, e.typ, e.cyc);
            end
         end
      end
      n_vec++; if (got_q.size() != 0) begin n_bad++; $display("FAIL pr_extra: got %0d extra events want 0", got_q.size()); got_q.delete(); end
   endtask

   task automatic test_glitch();
      logic [7:0] pat;
      pat = 8'b11011011;
      for (int i = 0; i < 8; i++) begin btn_in[2] = pat[i]; step(1); end
      btn_in[2] = 1'b0;
      step(60);
      n_vec++; if (level !== 4'b0000) begin n_bad++; $display("FAIL glitch_level: got %b want 0000", level); end
      n_vec++; if (got_q.size() != 0) begin n_bad++; $display("FAIL glitch_events: got %0d events want 0", got_q.size()); got_q.delete(); end
      n_vec++; if (drop_cnt != 0) begin n_bad++; $display("FAIL glitch_drop: got %0d drops want 0", drop_cnt); end
   endtask

   task automatic test_long_repeat();
      int k, L, F;
      ev_t e, g;
      k = cyc; btn_in[0] = 1'b1;
      wait_level(0, 1'b1, 40, L);
      n_vec++; if (L < 0) begin n_bad++; $display("FAIL lr_rise: level[0] never rose within 40 cycles"); L = cyc; end
      n_vec++; if (level !== 4'b0001) begin n_bad++; $display("FAIL lr_level: got %b want 0001", level); end
      push_ev(0, T_PRESS, L + 2);
      push_ev(0, T_LONG, L + 4 * LONGT + 1);
      step(k + 200 - cyc);
      btn_in[0] = 1'b0;
      wait_level(0, 1'b0, 40, F);
      n_vec++; if (F < 0) begin n_bad++; $display("FAIL lr_fall: level[0] never fell within 40 cycles"); F = cyc; end
      for (int t = L + 4 * (LONGT + REPT); t <= F; t += 4 * REPT) push_ev(0, T_REPEAT, t + 1);
      push_ev(0, T_RELEASE, F + 2);
      step(8);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_vec++;
         if (got_q.size() == 0) begin n_bad++; $display("FAIL lr_event: missing, want chan %0d type %0d at cycle %0d", e.chan, e.typ, e.cyc); end
         else begin
            g = got_q.pop_front();
            if (g.chan !== e.chan || g.typ !== e.typ || g.cyc !== e.cyc) begin
               n_bad++; $display("FAIL lr_event: got chan %0d type %0d cyc %0d want chan %0d type %0d cyc %0d", g.chan, g.typ, g.cyc, e.chan, e.typ, e.cyc);
            end
         end
      end
      n_vec++; if (got_q.size() != 0) begin n_bad++; $display("FAIL lr_extra: got %0d extra events want 0", got_q.size()); got_q.delete(); end
   endtask

   task automatic test_back_to_back();
      int L, F;
      ev_t e, g;
      rst_n = 1'b0; step(2); rst_n = 1'b1; ev_ready = 1'b1; step(2);
      btn_in = 4'hF;
      wait_level(3, 1'b1, 40, L);
      n_vec++; if (L < 0) begin n_bad++; $display("FAIL b2b_rise: levels never rose within 40 cycles"); L = cyc; end
      n_vec++; if (level !== 4'hF) begin n_bad++; $display("FAIL b2b_level: got %b want 1111", level); end
      for (int c = 0; c < N; c++) push_ev(c, T_PRESS, L + 2 + c);
      step(1);
      btn_in = 4'h0;
      wait_level(3, 1'b0, 40, F);
      n_vec++; if (F < 0) begin n_bad++; $display("FAIL b2b_fall: levels never fell within 40 cycles"); F = cyc; end
      n_vec++; if (level !== 4'h0) begin n_bad++; $display("FAIL b2b_level_fall: got %b want 0000", level); end
      for (int c = 0; c < N; c++) push_ev(c, T_RELEASE, F + 2 + c);
      step(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_vec++;
         if (got_q.size() == 0) begin n_bad++; $display("FAIL b2b_event: missing, want chan %0d type %0d at cycle %0d", e.chan, e.typ, e.cyc); end
         else begin
            g = got_q.pop_front();
            if (g.chan !== e.chan || g.typ !== e.typ || g.cyc !== e.cyc) begin
               n_bad++; $display("FAIL b2b_event: got chan %0d type %0d cyc %0d want chan %0d type %0d cyc %0d", g.chan, g.typ, g.cyc, e.chan, e.typ, e.cyc);
            end
         end
      end
      n_vec++; if (got_q.size() != 0) begin n_bad++; $display("FAIL b2b_extra: got %0d extra events want 0", got_q.size()); got_q.delete(); end
   endtask

   task automatic test_backpressure();
      int L, frozen_bad;
      ev_t e, g;
      ev_ready = 1'b0; drop_cnt = 0; last_drop_cyc = -1; frozen_bad = 0;
      btn_in[3] = 1'b1;
      wait_level(3, 1'b1, 40, L);
      n_vec++; if (L < 0) begin n_bad++; $display("FAIL bp_rise: level[3] never rose within 40 cycles"); L = cyc; end
      while (cyc < L + 4 * (LONGT + REPT) + 1) begin
         @(negedge clk);
         if (cyc >= L + 2 && !(ev_valid === 1'b1 && ev_chan === 2'd3 && ev_type === 2'd0)) frozen_bad++;
      end
      n_vec++; if (frozen_bad != 0) begin n_bad++; $display("FAIL bp_frozen: got %0d cycles not holding chan 3 PRESS want 0", frozen_bad); end
      n_vec++; if (drop_cnt != 1) begin n_bad++; $display("FAIL bp_drop_cnt: got %0d want 1", drop_cnt); end
      n_vec++; if (last_drop_cyc != L + 4 * (LONGT + REPT)) begin n_bad++; $display("FAIL bp_drop_cyc: got %0d want %0d", last_drop_cyc, L + 4 * (LONGT + REPT)); end
      @(posedge clk); #1;
      ev_ready = 1'b1;
      push_ev(3, T_PRESS, cyc);
      push_ev(3, T_LONG, cyc + 1);
      step(4);
      rst_n = 1'b0;
      #1;
      n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL bp_reset_valid: got %b want 0", ev_valid); end
      n_vec++; if (level !== 4'h0) begin n_bad++; $display("FAIL bp_reset_level: got %b want 0000", level); end
      btn_in[3] = 1'b0;
      step(3); rst_n = 1'b1; step(20);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_vec++;
         if (got_q.size() == 0) begin n_bad++; $display("FAIL bp_event: missing, want chan %0d type %0d at cycle %0d", e.chan, e.typ, e.cyc); end
         else begin
            g = got_q.pop_front();
            if (g.chan !== e.chan || g.typ !== e.typ || g.cyc !== e.cyc) begin
               n_bad++; $display("FAIL bp_event: got chan %0d type %0d cyc %0d want chan %0d type %0d cyc %0d", g.chan, g.typ, g.cyc, e.chan, e.typ, e.cyc);
            end
         end
      end
      n_vec++; if (got_q.size() != 0) begin n_bad++; $display("FAIL bp_extra: got %0d extra events want 0", got_q.size()); got_q.delete(); end
      n_vec++; if (drop_cnt != 1) begin n_bad++; $display("FAIL bp_drop_final: got %0d want 1", drop_cnt); end
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_glitch();
      test_long_repeat();
      test_back_to_back();
      test_backpressure();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Multi-channel button controller: N raw pushbutton inputs share one tick prescaler.
- Each channel is synchronized and debounced on ticks, then classified by a per-channel FSM into PRESS / RELEASE / LONG / REPEAT events.
- A round-robin arbiter serializes events onto a single valid/ready port consumed by the top-level control logic.

Parameters:
- N, 4, number of button channels (2..16)
- TICK_DIV, 50000, clk cycles per sample tick (>=2)
- STABLE_TICKS, 4, consecutive disagreeing ticks required to change debounced level (>=1)
- LONG_TICKS, 50, ticks held after PRESS before LONG event (>=1)
- REPEAT_TICKS, 10, ticks between REPEAT events while held (>=1)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- btn_in  input  N  raw asynchronous button levels, 1 = pressed
- level  output  N  debounced button levels
- ev_valid  output  1  event available
- ev_ready  input  1  consumer accepts event
- ev_chan  output  max(1,$clog2(N))  channel of event
- ev_type  output  2  0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
- ev_drop  output  1  one-cycle pulse: an event was discarded

Behaviour:
- Interface decided: clk is the clock; rst_n is asynchronous and active-low.
- Reset clears everything: sync FFs, counters and FSMs; level=0, ev_valid=0, ev_chan=0, ev_type=0, ev_drop=0, RR pointer=0, all pending slots empty. Reset mid-operation discards all pending and in-flight events with no further effect.
- Sync: 2-FF synchronizer per channel; only the synchronized value is used downstream.
- Tick: counter 0..TICK_DIV-1. tick=1 for one cycle when count==TICK_DIV-1; counter then wraps to 0.
- Debounce (per channel, on tick only):
  - sync!=level: stable counter +1. If the count reaches STABLE_TICKS, level<=sync and the counter clears.
  - sync==level: counter clears.
  - Glitches shorter than STABLE_TICKS ticks never change level.
- FSM per channel, states IDLE/DOWN/HELD. Evaluated on the cycle after level updates; event generation occurs only on that cycle or on a tick.
  - IDLE: level rises -> DOWN, emit PRESS, clear hold counter.
  - DOWN: each tick, hold+1. When hold reaches LONG_TICKS -> HELD, emit LONG, clear repeat counter.
  - HELD: each tick, rep+1. When rep reaches REPEAT_TICKS, emit REPEAT and clear rep.
  - DOWN/HELD: level falls -> IDLE, emit RELEASE. The fall takes priority over a same-cycle LONG/REPEAT.
- Pending slot: one entry per channel holding a 2-bit type.
  - New event while the slot is full and not being granted this cycle: new event discarded, ev_drop=1 next cycle.
  - Slot granted and a new event arrives in the same cycle: granted old content goes out, new event is stored, no drop.
- Arbiter/output:
  - The output register loads when ev_valid==0 or (ev_valid&&ev_ready).
  - Winner = first full slot searching upward from RR pointer, wrapping at N-1->0. On grant: slot cleared, pointer = winner+1 (mod N).
  - No full slot: ev_valid<=0 (after accept) or stays 0.
  - While ev_valid&&!ev_ready: ev_chan/ev_type held stable, and ev_valid is not deasserted.
  - Back-to-back: one event per cycle when ev_ready is held 1.
- Latency: from the cycle level changes to ev_valid, 2 cycles when the slot and output are free.
- Counter widths: sized by $clog2 of each limit. No counter wraps; all saturate/clear as described.

Test Plan:
Sim params N=4, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2.
- Reset, btn_in=0 for 200 cycles -> level=0, ev_valid never 1, ev_drop never 1.
- btn_in[1] 0->1 clean, ev_ready=1 -> level[1] rises on 3rd tick after sync sees 1. Two cycles later ev_valid=1, ev_chan=1, ev_type=0, for one cycle. Release -> ev_type=1 after the same latency.
- btn_in[2] pulses high for 8 cycles (2 ticks), bouncing 1-cycle glitches -> level[2] stays 0, no events.
- Hold btn_in[0] 200 cycles -> PRESS, LONG 8 ticks after PRESS level change, then REPEAT every 2 ticks. Release gives RELEASE, with no REPEAT on the release cycle.
- Channels 0..3 all pressed in the same cycle, ev_ready=1 -> 4 consecutive PRESS events, chan 0,1,2,3. A second simultaneous round (releases) gives order 0,1,2,3 (pointer wrapped).
- ev_ready=0 while channel 3 held through LONG and REPEAT -> ev_chan/ev_type frozen on PRESS. Second event is pending, third causes ev_drop pulse. Raise ev_ready -> PRESS, then LONG, then nothing extra. Assert rst_n low mid-stream -> ev_valid=0 immediately.
